// File: rtl/toggle_edge_sampler_if.sv
// Bus bundle between the toggle edge sampler and its environment.
// The harness uses the master modport, and the sampler uses the slave modport.
interface toggle_edge_sampler_if #(
    parameter int WIDTH = 22
);
    localparam int CW = $clog2(2*WIDTH+1);

    logic [WIDTH-1:0]   sig;
    logic               en;
    logic               clear;
    logic [2*WIDTH-1:0] valid;
    logic [CW-1:0]      covered_count;
    logic               all_covered;

    modport master (
        output sig, en, clear,
        input  valid, covered_count, all_covered
    );

    modport slave (
        input  sig, en, clear,
        output valid, covered_count, all_covered
    );
endinterface

// File: rtl/toggle_edge_sampler.sv
// Per-bit toggle detector feeding a toggle-coverage reporter, with sticky mask and point counter.
// Define TOGGLE_COVER_ONCE_EN to make each point pulse at most once until clear/reset.
module toggle_edge_lane (
    input  logic       clock,
    input  logic       reset,
    input  logic       sig,
    input  logic       qual,
    input  logic       clear,
    output logic [1:0] new_hit,
    output logic [1:0] pulse
);
    logic       prev_q;
    logic [1:0] mask_q;
    logic [1:0] hit;
    logic [1:0] base;

    // Bit 0 holds the rise and bit 1 holds the fall, which matches the reporter's interleave.
    always_comb begin
        hit     = {~sig & prev_q, sig & ~prev_q} & {2{qual}};
        base    = clear ? 2'b00 : mask_q;
        new_hit = hit & ~base;
    end

    // The sample register keeps tracking through reset, so the first cycle after release sees no edge.
    always_ff @(posedge clock) begin
        prev_q <= sig;
        if (reset) begin
            mask_q <= 2'b00;
            pulse  <= 2'b00;
        end else begin
            mask_q <= base | hit;
`ifdef TOGGLE_COVER_ONCE_EN
            pulse  <= new_hit;
`else
            pulse  <= hit;
`endif
        end
    end
endmodule

module toggle_edge_sampler #(
    parameter int WIDTH         = 22,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                   clock,
    input logic                   reset,
    toggle_edge_sampler_if.slave  bus
);
    localparam int CW = $clog2(2*WIDTH+1);

    logic [7:0]              arm_cnt;
    logic                    armed;
    logic                    qual;
    logic [WIDTH-1:0][1:0]   new_hits;
    logic [WIDTH-1:0][1:0]   pulse;
    logic [2*WIDTH-1:0]      new_flat;
    logic [CW-1:0]           pop;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           count_next;
    logic                    all_q;

    assign armed    = (arm_cnt == 8'(SETTLE_CYCLES));
    assign qual     = armed & bus.en;
    assign new_flat = new_hits;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            toggle_edge_lane u_lane (
                .clock   (clock),
                .reset   (reset),
                .sig     (bus.sig[g]),
                .qual    (qual),
                .clear   (bus.clear),
                .new_hit (new_hits[g]),
                .pulse   (pulse[g])
            );
        end
    endgenerate

    // New points are disjoint from the mask, so the sum can never exceed 2*WIDTH.
    always_comb begin
        pop = '0;
        for (int i = 0; i < 2*WIDTH; i++) pop = pop + CW'(new_flat[i]);
        count_next = (bus.clear ? '0 : count_q) + pop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            arm_cnt <= 8'd0;
            count_q <= '0;
            all_q   <= 1'b0;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + 8'd1;
            count_q <= count_next;
            all_q   <= (count_next == CW'(2*WIDTH));
        end
    end

    assign bus.valid         = pulse;
    assign bus.covered_count = count_q;
    assign bus.all_covered   = all_q;
endmodule

// File: tb/tb_toggle_edge_sampler.sv
// Scoreboard bench for toggle_edge_sampler: a cycle model pushes expected outputs, and each clock pops and compares them.
module tb_toggle_edge_sampler;
    localparam int W      = 22;
    localparam int SETTLE = 2;
    localparam int CW     = $clog2(2*W+1);

    typedef struct packed {
        logic [2*W-1:0] valid;
        logic [CW-1:0]  count;
        logic           all;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nchk  = 0;
    int   nerr  = 0;

    exp_t           sb[$];
    logic [W-1:0]   m_prev = '0;
    logic [2*W-1:0] m_mask = '0;
    int             m_count = 0;
    int             m_arm = 0;

    toggle_edge_sampler_if #(.WIDTH(W)) bus();

    toggle_edge_sampler #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, predict its registered result, then compare after the edge.
    task automatic drive(input logic [W-1:0] s, input logic e, input logic c, input logic r,
                         input string tag);
        exp_t x;
        exp_t y;
        logic [2*W-1:0] h;
        logic [2*W-1:0] nh;
        @(negedge clock);
        bus.sig   = s;
        bus.en    = e;
        bus.clear = c;
        reset     = r;
        x = '0;
        if (r) begin
            m_mask  = '0;
            m_count = 0;
            m_arm   = 0;
        end else begin
            h = '0;
            if (m_arm == SETTLE && e) begin
                for (int i = 0; i < W; i++) begin
                    if (s[i] && !m_prev[i]) h[2*i]   = 1'b1;
                    if (!s[i] && m_prev[i]) h[2*i+1] = 1'b1;
                end
            end
            if (c) begin
                m_mask  = '0;
                m_count = 0;
            end
            nh = h & ~m_mask;
            for (int i = 0; i < 2*W; i++) if (nh[i]) m_count++;
            m_mask = m_mask | h;
`ifdef TOGGLE_COVER_ONCE_EN
            x.valid = nh;
`else
            x.valid = h;
`endif
            x.count = CW'(m_count);
            x.all   = (m_count == 2*W);
            if (m_arm < SETTLE) m_arm++;
        end
        m_prev = s;
        sb.push_back(x);
        @(posedge clock);
        #1;
        y = sb.pop_front();
        chk({tag, ".valid"}, 64'(bus.valid), 64'(y.valid));
        chk({tag, ".count"}, 64'(bus.covered_count), 64'(y.count));
        chk({tag, ".all"}, 64'(bus.all_covered), 64'(y.all));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] rs;
        ones = '1;
        bus.sig   = ones;
        bus.en    = 1'b1;
        bus.clear = 1'b0;

        // Hold the inputs constant through reset and afterwards.
        repeat (3)  drive(ones, 1, 0, 1, "rst");
        repeat (10) drive(ones, 1, 0, 0, "const");

        // An edge inside the settle window is dropped. A later fall pulses valid bit 1.
        repeat (2) drive('0, 1, 0, 1, "rst2");
        drive(22'h1, 1, 0, 0, "settle_edge");
        repeat (4) drive(22'h1, 1, 0, 0, "settle_hold");
        drive(22'h0, 1, 0, 0, "fall0");
        drive(22'h0, 1, 0, 0, "fall0_after");
        chk("fall0_count", 64'(bus.covered_count), 64'd1);

        // Raise sig[3] twice. The second rise repeats or not, depending on the build.
        drive(22'h8, 1, 0, 0, "rise3a");
        repeat (2) drive(22'h8, 1, 0, 0, "hold3");
        drive(22'h0, 1, 0, 0, "fall3");
        drive(22'h8, 1, 0, 0, "rise3b");
        drive(22'h8, 1, 0, 0, "hold3b");

        // Toggle every bit up and then down to reach full coverage, and confirm it saturates.
        drive(ones, 1, 0, 0, "all_up");
        drive('0, 1, 0, 0, "all_dn");
        chk("full_count", 64'(bus.covered_count), 64'(2*W));
        chk("full_flag", 64'(bus.all_covered), 64'd1);
        drive(ones, 1, 0, 0, "all_up2");
        drive('0, 1, 0, 0, "all_dn2");

        // A clear in the same cycle as a rise of sig[5] leaves only that point recorded.
        drive(22'h20, 1, 1, 0, "clr_rise5");
        chk("clr_count", 64'(bus.covered_count), 64'd1);
        drive(22'h20, 1, 0, 0, "clr_hold");

        // Edges seen while en is low are lost, and are not replayed when en returns.
        drive(22'h24, 0, 0, 0, "en0_a");
        drive(22'h20, 0, 0, 0, "en0_b");
        drive(22'h24, 0, 0, 0, "en0_c");
        repeat (2) drive(22'h24, 1, 0, 0, "en1_stable");

        // Reset in the middle of a run discards the pending edge and restarts the settle window.
        drive(22'h25, 1, 0, 1, "mid_rst");
        drive(22'h24, 1, 0, 0, "post_rst0");
        drive(22'h26, 1, 0, 0, "post_rst1");
        drive(22'h26, 1, 0, 0, "post_rst2");
        drive(22'h27, 1, 0, 0, "post_rst3");

        // Random traffic with occasional en drops, clears and resets.
        for (int n = 0; n < 300; n++) begin
            rs = W'($urandom) & W'($urandom);
            drive(rs, ($urandom_range(0, 7) != 0), ($urandom_range(0, 40) == 0),
                  ($urandom_range(0, 60) == 0), "rand");
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
